cdma_receiver: RTL and testbench

CDMA_RECEIVER -- requirements
Module: cdma_receiver

---
 rtl/cdma_receiver.sv | 167 ++++++++++++++++
 tb/tb_cdma_receiver.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdma_receiver.sv
// cdma_receiver
// Single-channel DS-CDMA BPSK receiver. A 6-bit LFSR regenerates the
// spreading code of the selected user. Each received chip is scaled by the
// AGC gain, despread against that code and accumulated over a window of
// CHIPS chips. At the end of each window the receiver emits a hard data
// decision and a validity flag, then updates its RSSI estimate, the
// decision threshold and the AGC gain for the next window.
module cdma_receiver #(
    parameter int CHIPS       = 64,
    parameter int GAIN_UNITY  = 16,
    parameter int RSSI_TARGET = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bpsk_in,
    input  logic [5:0] user_code_1,
    input  logic [5:0] user_code_2,
    input  logic       user_select,
    output logic       data_out,
    output logic       data_valid
);

    localparam logic [5:0] LAST_CHIP = 6'(CHIPS - 1);
    localparam logic [7:0] GAIN_RST  = 8'(GAIN_UNITY);
    localparam logic [7:0] GAIN_MAX  = 8'd64;
    localparam logic [7:0] GAIN_MIN  = 8'd4;
    localparam logic [7:0] RSSI_LO   = 8'(RSSI_TARGET - 4);
    localparam logic [7:0] RSSI_HI   = 8'(RSSI_TARGET + 4);

    // Internal registers whose names are relied on by hierarchical probes.
    logic [5:0]  chip_count;
    logic [7:0]  gain_factor;
    logic [7:0]  rssi;
    logic [15:0] dynamic_threshold;

    logic [5:0]         r_lfsr;
    logic signed [23:0] r_acc;
    logic [15:0]        r_msum;
    logic               r_data_out;
    logic               r_data_valid;

    logic [5:0]         w_seed;
    logic [5:0]         w_seed_fixed;
    logic [5:0]         w_lfsr_cur;
    logic [5:0]         w_lfsr_next;
    logic               w_chip;
    logic               w_win_start;
    logic               w_win_end;
    logic signed [15:0] w_sample_ext;
    logic signed [15:0] w_gain_ext;
    logic signed [15:0] w_product;
    logic signed [15:0] w_gained;
    logic signed [23:0] w_gained_ext;
    logic signed [23:0] w_contrib;
    logic signed [23:0] w_acc_base;
    logic signed [23:0] w_acc_final;
    logic signed [23:0] w_acc_abs;
    logic signed [23:0] w_thr_ext;
    logic [15:0]        w_mag;
    logic [15:0]        w_msum_base;
    logic [16:0]        w_msum_sum;
    logic [15:0]        w_msum_final;
    logic [9:0]         w_rssi_wide;
    logic [7:0]         w_rssi_new;
    logic [15:0]        w_thr_new;
    logic [7:0]         w_gain_next;
    logic               w_decision;
    logic               w_valid_new;

    assign w_win_start = (chip_count == 6'd0);
    assign w_win_end   = (chip_count == LAST_CHIP);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign w_seed       = user_select ? user_code_2 : user_code_1;
    assign w_seed_fixed = (w_seed == 6'd0) ? 6'd1 : w_seed;

    // At a window start the code restarts from the seed selected right now,
    // so code/user changes mid-window only apply from the next window.
    assign w_lfsr_cur  = w_win_start ? w_seed_fixed : r_lfsr;
    assign w_chip      = w_lfsr_cur[5];
    assign w_lfsr_next = {w_lfsr_cur[4:0], w_lfsr_cur[5] ^ w_lfsr_cur[4]};

    // Gain is Q4.4; |bpsk_in * gain| stays below 2^15 for any 8-bit gain.
    assign w_sample_ext = {{8{bpsk_in[7]}}, bpsk_in};
    assign w_gain_ext   = {8'd0, gain_factor};
    assign w_product    = w_sample_ext * w_gain_ext;
    assign w_gained     = w_product >>> 4;
    assign w_gained_ext = {{8{w_gained[15]}}, w_gained};

    assign w_contrib   = w_chip ? w_gained_ext : -w_gained_ext;
    assign w_acc_base  = w_win_start ? 24'sd0 : r_acc;
    assign w_acc_final = w_acc_base + w_contrib;
    assign w_acc_abs   = w_acc_final[23] ? -w_acc_final : w_acc_final;

    assign w_mag        = w_gained[15] ? (16'd0 - w_gained) : w_gained;
    assign w_msum_base  = w_win_start ? 16'd0 : r_msum;
    assign w_msum_sum   = {1'b0, w_msum_base} + {1'b0, w_mag};
    assign w_msum_final = w_msum_sum[16] ? 16'hFFFF : w_msum_sum[15:0];

    assign w_rssi_wide = w_msum_final[15:6];
    assign w_rssi_new  = (|w_rssi_wide[9:8]) ? 8'hFF : w_rssi_wide[7:0];

    // Threshold is a quarter of the ideal correlation peak (rssi * CHIPS / 4).
    assign w_thr_new = {4'd0, w_rssi_new, 4'd0};
    assign w_thr_ext = {8'd0, dynamic_threshold};

    // A zero correlation resolves to a 0 decision.
    assign w_decision  = !w_acc_final[23] && (w_acc_final != 24'sd0);
    assign w_valid_new = (w_acc_abs > w_thr_ext);

    // AGC step: one unit per window toward the RSSI dead band, clamped.
    always_comb begin
        w_gain_next = gain_factor;
        if (w_rssi_new < RSSI_LO) begin
            if (gain_factor < GAIN_MAX) begin
                w_gain_next = gain_factor + 8'd1;
            end
        end else if (w_rssi_new > RSSI_HI) begin
            if (gain_factor > GAIN_MIN) begin
                w_gain_next = gain_factor - 8'd1;
            end
        end
    end

    // Chip counter and code generator; reset aligns to chip 0 of a window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            chip_count <= 6'd0;
            r_lfsr     <= w_seed_fixed;
        end else begin
            chip_count <= w_win_end ? 6'd0 : chip_count + 6'd1;
            r_lfsr     <= w_lfsr_next;
        end
    end

    // Correlation and magnitude accumulators; window start overwrites them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc  <= 24'sd0;
            r_msum <= 16'd0;
        end else begin
            r_acc  <= w_acc_final;
            r_msum <= w_msum_final;
        end
    end

    // End-of-window decision, RSSI, threshold and AGC update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data_out        <= 1'b0;
            r_data_valid      <= 1'b0;
            rssi              <= 8'd0;
            dynamic_threshold <= 16'd0;
            gain_factor       <= GAIN_RST;
        end else if (w_win_end) begin
            r_data_out        <= w_decision;
            r_data_valid      <= w_valid_new;
            rssi              <= w_rssi_new;
            dynamic_threshold <= w_thr_new;
            gain_factor       <= w_gain_next;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;

endmodule

// File: tb/tb_cdma_receiver.sv
// tb_cdma_receiver
// Directed and randomized windows against a window-level arithmetic model
// of the receiver (code sequence, correlation sum, RSSI, threshold, AGC).
module tb_cdma_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bpsk_in;
    logic [5:0] user_code_1;
    logic [5:0] user_code_2;
    logic       user_select;
    logic       data_out;
    logic       data_valid;

    always #5 clk = ~clk;

    cdma_receiver dut (
        .clk         (clk),
        .rst         (rst),
        .bpsk_in     (bpsk_in),
        .user_code_1 (user_code_1),
        .user_code_2 (user_code_2),
        .user_select (user_select),
        .data_out    (data_out),
        .data_valid  (data_valid)
    );

    int checks = 0;
    int errors = 0;
    int smp [64];

    int m_gain;
    int m_thr;
    int m_rssi;
    int m_out;
    int m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int code_chip(input int seed, input int k);
        int l;
        l = (seed == 0) ? 1 : seed;
        for (int i = 0; i < k; i++) l = ((l << 1) & 63) | (((l >> 5) ^ (l >> 4)) & 1);
        return (l >> 5) & 1;
    endfunction

    task automatic clear_smp();
        for (int k = 0; k < 64; k++) smp[k] = 0;
    endtask

    task automatic add_user(input int seed, input int bit_d, input int amp);
        for (int k = 0; k < 64; k++)
            smp[k] += (bit_d == code_chip(seed, k)) ? amp : -amp;
    endtask

    task automatic add_noise(input int span);
        for (int k = 0; k < 64; k++)
            smp[k] += int'($urandom_range(2 * span)) - span;
    endtask

    task automatic model_reset();
        m_gain = 16; m_thr = 0; m_rssi = 0; m_out = 0; m_valid = 0;
    endtask

    task automatic model_window(input int seed);
        int acc, msum, g, rs, aabs;
        acc = 0; msum = 0;
        for (int k = 0; k < 64; k++) begin
            g = (smp[k] * m_gain) >>> 4;
            acc += (code_chip(seed, k) == 1) ? g : -g;
            msum += (g < 0) ? -g : g;
        end
        if (msum > 65535) msum = 65535;
        rs = msum / 64;
        if (rs > 255) rs = 255;
        aabs = (acc < 0) ? -acc : acc;
        m_valid = (aabs > m_thr) ? 1 : 0;
        m_out   = (acc > 0) ? 1 : 0;
        m_rssi  = rs;
        m_thr   = rs * 16;
        if (rs < 28) begin
            if (m_gain < 64) m_gain++;
        end else if (rs > 36) begin
            if (m_gain > 4) m_gain--;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic play_window(input int seed, input int switch_at, input string tag);
        for (int k = 0; k < 64; k++) begin
            if (smp[k] > 127) smp[k] = 127;
            if (smp[k] < -128) smp[k] = -128;
        end
        for (int k = 0; k < 64; k++) begin
            if (k == 32) begin
                check({tag, "_hold_out"}, 32'(data_out), m_out);
                check({tag, "_hold_valid"}, 32'(data_valid), m_valid);
            end
            bpsk_in = 8'(smp[k]);
            if (k == switch_at) user_select = ~user_select;
            @(posedge clk);
            #1;
        end
        model_window(seed);
        check({tag, "_out"}, 32'(data_out), m_out);
        check({tag, "_valid"}, 32'(data_valid), m_valid);
        check({tag, "_rssi"}, 32'(dut.rssi), m_rssi);
        check({tag, "_thr"}, 32'(dut.dynamic_threshold), m_thr);
        check({tag, "_gain"}, 32'(dut.gain_factor), m_gain);
    endtask

    initial begin
        int acc_probe;
        int b1 [4];
        int b2 [4];
        int rbit, amp, seed_used, sw;

        rst = 1'b0;
        bpsk_in = 8'd0;
        user_code_1 = 6'b101011;
        user_code_2 = 6'b110101;
        user_select = 1'b0;
        model_reset();

        // Reset values
        do_reset();
        check("rst_out", 32'(data_out), 0);
        check("rst_valid", 32'(data_valid), 0);
        check("rst_chip_count", 32'(dut.chip_count), 0);
        check("rst_gain", 32'(dut.gain_factor), 16);
        check("rst_rssi", 32'(dut.rssi), 0);
        check("rst_thr", 32'(dut.dynamic_threshold), 0);

        // Single user, data 1 then data 0
        clear_smp(); add_user(43, 1, 32);
        play_window(43, -1, "single_d1");
        acc_probe = dut.r_acc;
        check("single_d1_acc", 32'(acc_probe), 2048);
        check("single_d1_bit", 32'(data_out), 1);
        check("single_d1_rssi32", 32'(dut.rssi), 32);
        check("single_d1_thr512", 32'(dut.dynamic_threshold), 512);
        clear_smp(); add_user(43, 0, 32);
        play_window(43, -1, "single_d0");
        acc_probe = dut.r_acc;
        check("single_d0_acc", 32'(acc_probe), -2048);
        check("single_d0_bit", 32'(data_out), 0);
        check("single_d0_valid", 32'(data_valid), 1);

        // Two summed users, each receiver recovers its own bits
        b1 = '{1, 0, 1, 0};
        b2 = '{1, 1, 0, 0};
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 2; s++) begin
                user_select = s[0];
                do_reset();
                clear_smp(); add_user(43, b1[i], 32); add_user(53, b2[i], 32);
                play_window((s == 0) ? 43 : 53, -1, "two_user");
                check("two_user_bit", 32'(data_out), (s == 0) ? b1[i] : b2[i]);
                check("two_user_valid", 32'(data_valid), 1);
            end
        end

        // Randomized windows: random codes/users/amplitudes/noise,
        // a zero seed, and user switches in the middle of a window
        do_reset();
        for (int w = 0; w < 12; w++) begin
            user_code_1 = 6'($urandom_range(63));
            user_code_2 = 6'($urandom_range(63));
            user_select = 1'($urandom_range(1));
            if (w == 3) begin
                user_code_1 = 6'd0;
                user_select = 1'b0;
            end
            seed_used = user_select ? int'(user_code_2) : int'(user_code_1);
            rbit = int'($urandom_range(1));
            amp  = int'($urandom_range(60, 10));
            sw   = ((w % 3) == 1) ? int'($urandom_range(62, 1)) : -1;
            clear_smp();
            add_user(seed_used, rbit, amp);
            add_user(user_select ? int'(user_code_1) : int'(user_code_2),
                     int'($urandom_range(1)), int'($urandom_range(20)));
            add_noise(15);
            play_window(seed_used, sw, "rand");
        end
        user_select = 1'b0;
        user_code_1 = 6'b101011;
        user_code_2 = 6'b110101;

        // Reset in the middle of a window discards the partial sum
        clear_smp(); add_user(43, 1, 50);
        for (int k = 0; k < 20; k++) begin
            bpsk_in = 8'(smp[k]);
            @(posedge clk);
            #1;
        end
        do_reset();
        check("midrst_chip_count", 32'(dut.chip_count), 0);
        check("midrst_out", 32'(data_out), 0);
        clear_smp(); add_user(43, 0, 24); add_noise(5);
        play_window(43, -1, "midrst");

        // Weak signal: gain climbs one step per window and settles
        do_reset();
        for (int w = 0; w < 20; w++) begin
            clear_smp(); add_user(43, int'($urandom_range(1)), 16);
            play_window(43, -1, "agc_up");
        end
        check("agc_up_settle", 32'(dut.gain_factor), 28);

        // Silent window: zero correlation, decision 0 and not valid
        clear_smp();
        play_window(43, -1, "silent");
        check("silent_valid0", 32'(data_valid), 0);
        check("silent_out0", 32'(data_out), 0);

        // Very weak signal drives gain into its upper clamp
        for (int w = 0; w < 40; w++) begin
            clear_smp(); add_user(43, int'($urandom_range(1)), 1);
            play_window(43, -1, "agc_max");
        end
        check("agc_max_clamp", 32'(dut.gain_factor), 64);

        // Full-scale input at maximum gain saturates rssi
        clear_smp();
        for (int k = 0; k < 64; k++) smp[k] = -128;
        play_window(43, -1, "rssi_sat");
        check("rssi_sat_255", 32'(dut.rssi), 255);

        // Strong signal: gain falls until rssi enters the dead band
        for (int w = 0; w < 65; w++) begin
            clear_smp(); add_user(43, int'($urandom_range(1)), 100);
            play_window(43, -1, "agc_down");
        end
        check("agc_down_band", 32'((dut.rssi >= 8'd28) && (dut.rssi <= 8'd36)), 1);
        check("agc_down_gain", 32'(dut.gain_factor), 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
